// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin owner of one FIFO write port with burst locking; first write 1 cycle after grant.
// Backpressure: FIFO_FULL gates WR_EN and the owner's READY in the same cycle; the owner stalls in place.
`timescale 1ns/1ps
module fifo_wr_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]       REQ_READY,
  input  logic                     FIFO_FULL,
  output logic                     FIFO_WR_EN,
  output logic [WIDTH-1:0]         FIFO_DATA,
  output logic                     GNT_VALID,
  output logic [ID_W-1:0]          GNT_ID
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state;
  logic [ID_W-1:0]      owner;
  logic [ID_W-1:0]      last;
  logic [CNT_W-1:0]     beats;

  logic [ID_W-1:0]      pick;
  logic                 found;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 own_vld;
  logic                 xfer;
  logic                 burst_end;
  logic [WIDTH-1:0]     owner_dat;

  assign own_vld   = REQ_VALID[owner];
  assign owner_dat = REQ_DATA[owner*WIDTH +: WIDTH];
  assign xfer      = (state == OWN) & own_vld & ~FIFO_FULL;
  assign burst_end = (beats == CNT_W'(MAX_BURST - 1));

  // Rotate so bit 0 is the requester just after the previous owner; first set bit wins.
  always_comb begin
    dbl   = {REQ_VALID, REQ_VALID};
    rot   = NUM_REQ'(dbl >> (int'(last) + 1));
    pick  = last;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        pick  = ID_W'((int'(last) + 1 + j) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    REQ_READY  = '0;
    FIFO_WR_EN = 1'b0;
    FIFO_DATA  = '0;
    GNT_VALID  = 1'b0;
    GNT_ID     = '0;
    if (state == OWN) begin
      GNT_VALID        = 1'b1;
      GNT_ID           = owner;
      REQ_READY[owner] = ~FIFO_FULL;
      FIFO_WR_EN       = xfer;
      FIFO_DATA        = xfer ? owner_dat : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      owner <= '0;
      last  <= ID_W'(NUM_REQ - 1);
      beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|REQ_VALID) begin
            owner <= pick;
            beats <= '0;
            state <= OWN;
          end
        end
        OWN: begin
          if (xfer) begin
            if (burst_end) begin
              last  <= owner;
              state <= IDLE;
            end else begin
              beats <= beats + 1'b1;
            end
          end else if (!own_vld) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Bench: producers, an 8-deep FIFO model with random reader, rule-level arbitration model and per-source scoreboard.
`timescale 1ns/1ps
module tb_fifo_wr_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int MB = 4;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [N-1:0] REQ_VALID = '0;
  logic [N*W-1:0] REQ_DATA = '0;
  logic [N-1:0] REQ_READY;
  logic FIFO_FULL;
  logic FIFO_WR_EN;
  logic [W-1:0] FIFO_DATA;
  logic GNT_VALID;
  logic [1:0] GNT_ID;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] prod_q [N][$];
  logic [7:0] exp_q [N][$];
  logic [7:0] fifo_q [$];
  logic [5:0] seq [N];
  logic [N-1:0] vld = '0;
  logic force_full = 1'b0;
  int rd_prob = 100;
  int gap_pct = 0;
  int fifo_cnt = 0;

  logic samp_wr = 1'b0;
  logic [7:0] samp_dat = '0;
  logic [N-1:0] samp_xfer = '0;

  bit m_own = 1'b0;
  int m_id = 0;
  int m_last = N - 1;
  int m_cnt = 0;

  typedef struct {int id; int wr; int idle;} ten_t;
  ten_t ten_log [$];
  ten_t cur;
  bit in_ten = 1'b0;
  int idle_run = 0;
  int stall_cnt = 0;
  int phase_wr = 0;

  assign FIFO_FULL = (fifo_cnt >= DEPTH) | force_full;

  fifo_wr_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY),
    .FIFO_FULL(FIFO_FULL), .FIFO_WR_EN(FIFO_WR_EN), .FIFO_DATA(FIFO_DATA),
    .GNT_VALID(GNT_VALID), .GNT_ID(GNT_ID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, not allowed here (t=%0t)", nm, act, $time);
  endtask

  task automatic chk_ten(input string nm, input int idx, input int id, input int wr);
    if (idx >= ten_log.size()) fail({nm, "_missing"}, ten_log.size());
    else begin
      chk({nm, "_id"}, ten_log[idx].id, id);
      chk({nm, "_writes"}, ten_log[idx].wr, wr);
    end
  endtask

  // Each issued word is queued both for its producer and as the expected FIFO output of that source.
  task automatic issue(input int k, input int n);
    logic [1:0] kk;
    logic [7:0] w;
    kk = k[1:0];
    for (int i = 0; i < n; i++) begin
      w = {kk, seq[k]};
      seq[k] = seq[k] + 6'd1;
      prod_q[k].push_back(w);
      exp_q[k].push_back(w);
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = (fifo_q.size() == 0);
    for (int k = 0; k < N; k++) if (prod_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(posedge CLK); #2;
      done = all_empty();
    end
    if (!done) fail("drain_timeout", fifo_q.size());
    repeat (3) @(posedge CLK);
    #2;
  endtask

  task automatic wait_writes(input int n);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge CLK); #2;
      done = (phase_wr >= n);
    end
    if (!done) fail("write_wait_timeout", phase_wr);
  endtask

  // Monitor: compares DUT outputs with the arbitration rules, then advances the model.
  always @(negedge CLK) begin
    logic [3:0] exp_rdy;
    logic exp_wr;
    logic [7:0] exp_dat;
    bit ov;
    int c;
    if (!RST) begin
      chk("reset_outputs", 32'({GNT_VALID, GNT_ID, REQ_READY, FIFO_WR_EN, FIFO_DATA}), 32'h0);
      m_own = 1'b0; m_id = 0; m_last = N - 1; m_cnt = 0;
      samp_wr = 1'b0; samp_xfer = '0; in_ten = 1'b0; idle_run = 0;
    end else begin
      ov = m_own && REQ_VALID[m_id[1:0]];
      exp_rdy = (m_own && !FIFO_FULL) ? (4'b0001 << m_id) : 4'b0000;
      exp_wr = ov && !FIFO_FULL;
      exp_dat = exp_wr ? REQ_DATA[m_id*W +: W] : 8'h00;
      chk("gnt_valid", 32'(GNT_VALID), 32'(m_own));
      chk("gnt_id", 32'(GNT_ID), m_own ? m_id : 0);
      chk("req_ready", 32'(REQ_READY), 32'(exp_rdy));
      chk("fifo_wr_en", 32'(FIFO_WR_EN), 32'(exp_wr));
      chk("fifo_data", 32'(FIFO_DATA), 32'(exp_dat));
      if (GNT_VALID && FIFO_FULL) stall_cnt++;

      if (GNT_VALID) begin
        if (!in_ten) begin
          in_ten = 1'b1; cur.id = int'(GNT_ID); cur.wr = 0; cur.idle = idle_run;
        end
        if (FIFO_WR_EN) cur.wr++;
      end else begin
        if (in_ten) begin
          ten_log.push_back(cur); in_ten = 1'b0; idle_run = 0;
        end
        idle_run++;
      end

      samp_wr = FIFO_WR_EN;
      samp_dat = FIFO_DATA;
      samp_xfer = REQ_VALID & REQ_READY;

      if (!m_own) begin
        if (REQ_VALID != '0) begin
          for (int i = 1; i <= N; i++) begin
            c = (m_last + i) % N;
            if (REQ_VALID[c[1:0]]) begin m_id = c; break; end
          end
          m_own = 1'b1; m_cnt = 0;
        end
      end else if (exp_wr) begin
        m_cnt++;
        if (m_cnt == MB) begin m_own = 1'b0; m_last = m_id; end
      end else if (!ov) begin
        m_own = 1'b0; m_last = m_id;
      end
    end
  end

  // Environment: FIFO model with random reader, producers honouring the hold-until-accepted rule.
  always @(posedge CLK) begin
    int pre;
    int s;
    logic [7:0] w;
    logic [7:0] e;
    #1;
    pre = fifo_q.size();
    if (pre > 0 && $urandom_range(99) < rd_prob) begin
      w = fifo_q.pop_front();
      s = int'(w[7:6]);
      if (exp_q[s].size() == 0) fail("fifo_unexpected_word", w);
      else begin
        e = exp_q[s].pop_front();
        chk("fifo_word_order", w, e);
      end
    end
    if (samp_wr) begin
      if (pre >= DEPTH) fail("write_while_full", pre);
      fifo_q.push_back(samp_dat);
      phase_wr++;
    end
    for (int k = 0; k < N; k++) begin
      if (samp_xfer[k]) begin
        if (prod_q[k].size() > 0) void'(prod_q[k].pop_front());
        vld[k] = 1'b0;
      end
      if (!vld[k] && prod_q[k].size() > 0 && $urandom_range(99) >= gap_pct) vld[k] = 1'b1;
      if (vld[k]) REQ_DATA[k*W +: W] = prod_q[k][0];
      else REQ_DATA[k*W +: W] = 8'($urandom);
    end
    REQ_VALID = vld;
    fifo_cnt = fifo_q.size();
    samp_wr = 1'b0;
    samp_xfer = '0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) seq[k] = 6'd0;

    // Requesters 0 and 2 valid while reset is held.
    issue(0, 8); issue(2, 4);
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    wait_drain(200);
    chk_ten("t1_first", 0, 0, 4);
    chk_ten("t1_second", 1, 2, 4);
    chk_ten("t1_third", 2, 0, 4);

    // Saturated round starting after requester 3.
    issue(3, 1); wait_drain(100);
    ten_log.delete();
    for (int k = 0; k < N; k++) issue(k, 8);
    wait_drain(400);
    for (int i = 0; i < 5; i++) chk_ten("t2_round", i, i % N, 4);
    for (int i = 1; i < 5; i++)
      if (i < ten_log.size()) chk("t2_idle_gap", ten_log[i].idle, 1);

    // FULL forced for 3 cycles after the second beat.
    ten_log.delete(); stall_cnt = 0; phase_wr = 0;
    issue(1, 4);
    wait_writes(2);
    force_full = 1'b1;
    repeat (3) @(posedge CLK);
    #2 force_full = 1'b0;
    wait_drain(100);
    chk("t3_stall_cycles", stall_cnt, 3);
    chk("t3_tenures", ten_log.size(), 1);
    chk_ten("t3_tenure", 0, 1, 4);

    // Early release by requester 1.
    issue(0, 1); wait_drain(100);
    ten_log.delete(); phase_wr = 0;
    issue(1, 2); issue(2, 3); issue(3, 3);
    wait_drain(200);
    chk_ten("t4_release", 0, 1, 2);
    chk_ten("t4_next", 1, 2, 3);
    chk_ten("t4_last", 2, 3, 3);
    chk("t4_words", phase_wr, 8);

    // Reset in the middle of requester 3's tenure.
    issue(2, 1); wait_drain(100);
    ten_log.delete(); phase_wr = 0;
    issue(3, 4); issue(0, 4);
    wait_writes(1);
    chk("t5_owner_before_reset", 32'({GNT_VALID, GNT_ID}), 32'h7);
    RST = 1'b0;
    #1;
    chk("t5_async_reset", 32'({GNT_VALID, GNT_ID, REQ_READY, FIFO_WR_EN, FIFO_DATA}), 32'h0);
    repeat (2) @(posedge CLK);
    #2;
    ten_log.delete();
    RST = 1'b1;
    wait_drain(200);
    chk_ten("t5_first_after_reset", 0, 0, 4);
    chk_ten("t5_resume", 1, 3, 3);

    // Random producers and reader through the 8-deep FIFO.
    phase_wr = 0; rd_prob = 40; gap_pct = 30;
    for (int k = 0; k < N; k++) issue(k, 5);
    wait_drain(3000);
    chk("t6_words_written", phase_wr, 20);
    for (int k = 0; k < N; k++) chk("t6_source_drained", exp_q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
